// File: rtl/mic_pkg.sv
// Shared types and default geometry for the mic capture frame buffer.
package mic_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 256;
  localparam int AW_DEF    = 8;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAIT_RD = 2'd1,
    SWAP    = 2'd2
  } state_t;

endpackage

// File: rtl/frame_fill_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {W{1'b1}})) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/frame_fill_ctrl.sv
// Fills one half of a ping-pong sample buffer and hands it to the reader
// once the reader has released the other half.
//
// state   | meaning
// FILL    | writing incoming samples at wr_ptr
// WAIT_RD | frame full, reader still busy; incoming samples are dropped
// SWAP    | one-cycle buffer swap; pulse timeToSwitch, count the frame
module frame_fill_ctrl
  import mic_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          rd_done,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          wren,
  output logic          timeToSwitch,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt,
  output logic          overflow
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic          r_reader_free;
  logic          w_drop;

  assign w_drop = (r_state == WAIT_RD) && s_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FILL;
      r_wr_ptr      <= '0;
      r_reader_free <= 1'b1;
      wren          <= 1'b0;
      w_addr        <= '0;
      w_data        <= '0;
      timeToSwitch  <= 1'b0;
      frame_cnt     <= '0;
      overflow      <= 1'b0;
    end else begin
      wren         <= 1'b0;
      timeToSwitch <= 1'b0;
      overflow     <= overflow | w_drop;
      // Entering SWAP below overrides this and consumes the release.
      if (rd_done) begin
        r_reader_free <= 1'b1;
      end

      case (r_state)
        FILL: begin
          if (s_valid) begin
            wren     <= 1'b1;
            w_addr   <= r_wr_ptr;
            w_data   <= s_data;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LAST_ADDR) begin
              if (r_reader_free || rd_done) begin
                r_state       <= SWAP;
                r_reader_free <= 1'b0;
              end else begin
                r_state <= WAIT_RD;
              end
            end
          end
        end

        WAIT_RD: begin
          if (rd_done) begin
            r_state       <= SWAP;
            r_reader_free <= 1'b0;
          end
        end

        SWAP: begin
          timeToSwitch <= 1'b1;
          frame_cnt    <= frame_cnt + 16'd1;
          r_state      <= FILL;
          // wr_ptr already wrapped, so this lands at address 0 of the new frame.
          if (s_valid) begin
            wren     <= 1'b1;
            w_addr   <= r_wr_ptr;
            w_data   <= s_data;
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end

        default: r_state <= FILL;
      endcase
    end
  end

  sat_counter #(.W(16)) u_drop_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_drop),
    .o_count (drop_cnt)
  );

endmodule

// File: tb/tb_frame_fill_ctrl.sv
// Directed bench for frame_fill_ctrl with default geometry (DW=32, DEPTH=256).
module tb_frame_fill_ctrl;
  import mic_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        rd_done = 1'b0;
  logic [7:0]  w_addr;
  logic [31:0] w_data;
  logic        wren;
  logic        timeToSwitch;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_err    = 0;

  frame_fill_ctrl #(.DW(32), .DEPTH(256), .AW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .rd_done      (rd_done),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .wren         (wren),
    .timeToSwitch (timeToSwitch),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wren"},  32'(wren), 32'd0);
    chk({tag, "_waddr"}, 32'(w_addr), 32'd0);
    chk({tag, "_wdata"}, w_data, 32'd0);
    chk({tag, "_tts"},   32'(timeToSwitch), 32'd0);
    chk({tag, "_frame"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_drop"},  32'(drop_cnt), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
    chk({tag, "_state"}, 32'(dut.r_state), 32'(FILL));
  endtask

  // Writes a full frame of samples (data = index ^ xorv) starting at the
  // current write pointer assumed to be 0; counts cycles that disagree.
  task automatic write_frame(input logic [31:0] xorv, input bit rd_last, output int bad);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i) ^ xorv;
      rd_done = rd_last && (i == 255);
      tick();
      if (!(wren === 1'b1 && w_addr === 8'(i) && w_data === (32'(i) ^ xorv)
            && timeToSwitch === 1'b0))
        bad++;
    end
    s_valid = 1'b0;
    rd_done = 1'b0;
  endtask

  initial begin
    int bad;
    int pulses;

    // Reset values
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Full frame into a free reader: direct swap, pulse two cycles after last sample
    write_frame(32'h0, 1'b0, bad);
    chk("f1_writes", 32'(bad), 32'd0);
    chk("f1_state_swap", 32'(dut.r_state), 32'(SWAP));
    tick();
    chk("f1_tts", 32'(timeToSwitch), 32'd1);
    chk("f1_frame", 32'(frame_cnt), 32'd1);
    chk("f1_wren_idle", 32'(wren), 32'd0);
    tick();
    chk("f1_tts_low", 32'(timeToSwitch), 32'd0);
    chk("f1_state_fill", 32'(dut.r_state), 32'(FILL));

    // Reader busy: frame stalls, drops counted, then rd_done releases it
    write_frame(32'hA5A5_0000, 1'b0, bad);
    chk("f2_writes", 32'(bad), 32'd0);
    chk("f2_state_wait", 32'(dut.r_state), 32'(WAIT_RD));
    tick();
    chk("f2_no_pulse", 32'(timeToSwitch), 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h1234_0000 + 32'(i);
      tick();
      if (wren !== 1'b0) bad++;
    end
    s_valid = 1'b0;
    chk("f2_drop_nowren", 32'(bad), 32'd0);
    chk("f2_drop_cnt", 32'(drop_cnt), 32'd10);
    chk("f2_ovf", 32'(overflow), 32'd1);
    chk("f2_still_wait", 32'(dut.r_state), 32'(WAIT_RD));
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("f2_state_swap", 32'(dut.r_state), 32'(SWAP));
    chk("f2_tts_pre", 32'(timeToSwitch), 32'd0);
    tick();
    chk("f2_tts", 32'(timeToSwitch), 32'd1);
    chk("f2_frame", 32'(frame_cnt), 32'd2);
    tick();
    chk("f2_tts_low", 32'(timeToSwitch), 32'd0);

    // rd_done on the last write: direct swap; sample in SWAP lands at address 0
    write_frame(32'h0F0F_0000, 1'b1, bad);
    chk("f3_writes", 32'(bad), 32'd0);
    chk("f3_state_swap", 32'(dut.r_state), 32'(SWAP));
    chk("f3_drop_same", 32'(drop_cnt), 32'd10);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    tick();
    s_valid = 1'b0;
    chk("swap_wr_wren", 32'(wren), 32'd1);
    chk("swap_wr_addr", 32'(w_addr), 32'd0);
    chk("swap_wr_data", w_data, 32'hDEAD_BEEF);
    chk("swap_wr_tts", 32'(timeToSwitch), 32'd1);
    chk("swap_wr_frame", 32'(frame_cnt), 32'd3);
    chk("swap_wr_drop", 32'(drop_cnt), 32'd10);

    // Redundant rd_done in FILL only re-arms the reader
    rd_done = 1'b1;
    tick();
    tick();
    rd_done = 1'b0;
    chk("rd_fill_state", 32'(dut.r_state), 32'(FILL));
    chk("rd_fill_free", 32'(dut.r_reader_free), 32'd1);
    chk("rd_fill_frame", 32'(frame_cnt), 32'd3);

    // 99 more writes (addresses 1..99) make 100 in this frame, then reset
    bad = 0;
    for (int i = 1; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i);
      tick();
      if (!(wren === 1'b1 && w_addr === 8'(i))) bad++;
    end
    s_valid = 1'b0;
    chk("part_writes", 32'(bad), 32'd0);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    write_frame(32'h5555_0000, 1'b0, bad);
    chk("post_rst_writes", 32'(bad), 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (timeToSwitch === 1'b1) pulses++;
    end
    chk("post_rst_pulses", 32'(pulses), 32'd1);
    chk("post_rst_frame", 32'(frame_cnt), 32'd1);

    // Drop counter saturation: reader still holds the frame from before
    write_frame(32'h3333_0000, 1'b0, bad);
    chk("sat_fill_writes", 32'(bad), 32'd0);
    chk("sat_state_wait", 32'(dut.r_state), 32'(WAIT_RD));
    s_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      s_data = 32'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("sat_drop", 32'(drop_cnt), 32'd65535);
    chk("sat_ovf", 32'(overflow), 32'd1);
    chk("sat_wren", 32'(wren), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_fill_ctrl.md
FRAME_FILL_CTRL -- requirements
Module: frame_fill_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, sample/word width.
REQ-002 SHALL have parameter DEPTH, default 256, words per frame (power of two).
REQ-003 SHALL have parameter AW, default 8, equal to log2(DEPTH).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  one sample present on s_data this cycle.
REQ-007 SHALL have port s_data  input  DW  sample word from the mic capture path.
REQ-008 SHALL have port rd_done  input  1  one-cycle pulse: reader finished consuming the current read-side frame.
REQ-009 SHALL have port w_addr  output  AW  write address to the ping-pong buffer.
REQ-010 SHALL have port w_data  output  DW  write data to the ping-pong buffer.
REQ-011 SHALL have port wren  output  1  write enable to the ping-pong buffer.
REQ-012 SHALL have port timeToSwitch  output  1  registered one-cycle buffer-swap pulse.
REQ-013 SHALL have port frame_cnt  output  16  completed-and-swapped frames, wraps at 65535->0.
REQ-014 SHALL have port drop_cnt  output  16  samples discarded while stalled, saturates at 65535.
REQ-015 SHALL have port overflow  output  1  sticky flag, set on the first dropped sample.

Function
REQ-016 SHALL implement FSM states FILL, WAIT_RD, SWAP.
REQ-017 In FILL, each s_valid SHALL produce wren=1, w_addr=wr_ptr, w_data=s_data, registered (one-cycle latency from s_valid), then increment wr_ptr.
REQ-018 A write at wr_ptr=DEPTH-1 SHALL wrap wr_ptr to 0 and transition to SWAP if reader_free=1 (including rd_done in the same cycle), otherwise to WAIT_RD.
REQ-019 reader_free SHALL set on rd_done, clear when SWAP is entered, and SHALL be 1 after reset.
REQ-020 In WAIT_RD, s_valid samples SHALL NOT be written; each one SHALL increment drop_cnt (saturating) and set overflow.
REQ-021 WAIT_RD SHALL go to SWAP in the cycle after rd_done is seen.
REQ-022 SWAP SHALL last exactly one cycle: timeToSwitch=1 and frame_cnt+1, then return to FILL.
REQ-023 An s_valid arriving during SWAP SHALL be written at address 0 of the new frame (no drop).
REQ-024 timeToSwitch SHALL never be asserted in a cycle where wren=1 at w_addr=DEPTH-1; the last write completes at least one cycle earlier.
REQ-025 rd_done while in FILL SHALL only set reader_free; a redundant rd_done SHALL have no further effect.
REQ-026 wren SHALL be 0 whenever s_valid was 0 or the state was WAIT_RD.

Reset
REQ-027 On reset: state=FILL, wr_ptr=0, reader_free=1, wren=0, w_addr=0, w_data=0, timeToSwitch=0, frame_cnt=0, drop_cnt=0, overflow=0.
REQ-028 Reset mid-frame SHALL abandon the partial frame with no timeToSwitch pulse; the pulse SHALL drop in the same edge if it is high.

Structure
REQ-029 The state_t enum (FILL, WAIT_RD, SWAP) and the default DW/DEPTH/AW constants SHALL live in the shared mic_pkg package.
REQ-030 The design SHALL be one flat module; a shared saturating-counter sub-module sat_counter SHALL be used for drop_cnt.

Verification
REQ-031 Reset, then 256 consecutive s_valid with data=addr -> writes 0..255 in order, one timeToSwitch pulse two cycles after the last s_valid, frame_cnt=1.
REQ-032 Fill frame 1 without rd_done, then send 10 samples -> state WAIT_RD, drop_cnt=10, overflow=1, no wren; then rd_done -> timeToSwitch next cycle, frame_cnt=2.
REQ-033 rd_done in the same cycle as the write to 255 of frame 2 -> direct SWAP, drop_cnt unchanged.
REQ-034 s_valid in the SWAP cycle with data 0xDEADBEEF -> written to w_addr=0, no drop.
REQ-035 Reset after 100 writes -> all outputs at reset values, then 256 writes start at address 0, with exactly one pulse at the end.
REQ-036 Force 65540 drops -> drop_cnt holds 65535 and overflow stays 1.
